// File: rtl/sync_reg_rx.sv
// Receiving end of a 4-phase req/ack register transfer.
// Synchronizes req, captures the held word into a FIFO, and stalls ack while the FIFO is full.
module sync_reg_rx #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_async,
  input  logic [WIDTH-1:0]           data_async,
  output logic                       ack,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_ACK
  } state_t;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ack;
  logic             r_err;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_req_s;
  logic w_full;
  logic w_pop;
  logic w_wr_ok;
  logic w_push;
  logic w_err_set;

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr_ok = !w_full || w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_async};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_s) begin
          if (w_wr_ok) begin
            w_push      = 1'b1;
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!w_req_s) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_wr_ok) begin
          w_push      = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == S_ACK);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_async;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set dominates clear so a withdrawal coinciding with err_clr is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign ack       = r_ack;
  assign err       = r_err;
  assign count     = r_count;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_sync_reg_rx.sv
// Self-checking bench for sync_reg_rx: table-driven fill, directed corner cases,
// and randomized transfers scored against a queue-based model of the FIFO contents.
module tb_sync_reg_rx;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_async = 1'b0;
  logic [W-1:0] data_async = '0;
  logic         ack;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   count;
  logic         err;
  logic         err_clr = 1'b0;

  sync_reg_rx #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_async  (req_async),
    .data_async (data_async),
    .ack        (ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise req with d and count edges until ack is seen (bounded).
  task automatic raise_wait(input logic [W-1:0] d, output int lat);
    data_async = d;
    req_async  = 1'b1;
    lat = 0;
    while (!ack && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic drop_wait(output int lat);
    req_async = 1'b0;
    lat = 0;
    while (ack && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic send_full(input logic [W-1:0] d);
    int l;
    raise_wait(d, l);
    if (!ack) check("send_ack_timeout", ack, 1);
    drop_wait(l);
    if (ack) check("send_release_timeout", ack, 0);
  endtask

  // Queue model used during the randomized phase.
  logic [W-1:0] q[$];
  bit           mon_en = 0;
  bit           pop_pend = 0;
  logic         prev_ack = 1'b0;
  int           popped = 0;
  int           max_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pop_pend && q.size() != 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (ack && !prev_ack) q.push_back(data_async);
      prev_ack = ack;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      check("rnd_count", count, q.size());
      check("rnd_valid", out_valid, (q.size() != 0));
      pop_pend = out_valid && out_ready;
      if (pop_pend && q.size() != 0) check("rnd_order", out_data, q[0]);
    end
  end

  typedef struct {
    logic [W-1:0] data;
    int           exp_lat;
    int           exp_cnt;
    logic [W-1:0] exp_head;
    int           exp_rel;
  } vec_t;

  vec_t         tbl[4];
  logic [W-1:0] drain_exp[4];
  bit           snd_done;

  initial begin
    int lat;
    logic seen;

    // Capture at edge SYNC_STAGES+1; release: first low sample plus two edges.
    tbl[0] = '{8'h01, 3, 1, 8'h01, 3};
    tbl[1] = '{8'h02, 3, 2, 8'h01, 3};
    tbl[2] = '{8'h03, 3, 3, 8'h01, 3};
    tbl[3] = '{8'h04, 3, 4, 8'h01, 3};
    drain_exp[0] = 8'h02;
    drain_exp[1] = 8'h03;
    drain_exp[2] = 8'h04;
    drain_exp[3] = 8'h05;

    repeat (3) tick();
    check("rst_ack", ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Single transfer with consumer always ready.
    out_ready = 1'b1;
    raise_wait(8'hA5, lat);
    check("single_ack_lat", lat, 3);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 8'hA5);
    check("single_count", count, 1);
    tick();
    check("single_popped_valid", out_valid, 0);
    check("single_count0", count, 0);
    check("single_ack_held", ack, 1);
    drop_wait(lat);
    check("single_rel_lat", lat, 3);

    // Table-driven fill with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      raise_wait(tbl[i].data, lat);
      check("fill_ack_lat", lat, tbl[i].exp_lat);
      check("fill_count", count, tbl[i].exp_cnt);
      check("fill_head", out_data, tbl[i].exp_head);
      check("fill_valid", out_valid, 1);
      drop_wait(lat);
      check("fill_rel_lat", lat, tbl[i].exp_rel);
    end

    // Fifth word is held off until a pop frees a slot.
    data_async = 8'h05;
    req_async  = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= ack;
    end
    check("hold_no_ack", seen, 0);
    check("hold_count", count, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_ack", ack, 1);
    check("hold_count_same", count, 4);
    check("hold_head", out_data, 8'h02);
    drop_wait(lat);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, drain_exp[i]);
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_valid_end", out_valid, 0);

    // Withdrawal while full raises err.
    for (int i = 0; i < 4; i++) send_full(8'(32 + i));
    check("err_fill_count", count, 4);
    data_async = 8'h99;
    req_async  = 1'b1;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= ack; end
    req_async = 1'b0;
    repeat (5) begin tick(); seen |= ack; end
    check("err_no_ack", seen, 0);
    check("err_set", err, 1);
    check("err_count", count, 4);
    check("err_head", out_data, 8'h20);
    tick();
    check("err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", err, 0);

    // Clear held across the cycle of a new withdrawal: set must win.
    req_async = 1'b1;
    repeat (5) tick();
    req_async = 1'b0;
    err_clr   = 1'b1;
    repeat (3) tick();
    err_clr = 1'b0;
    check("err_set_wins", err, 1);
    tick();
    check("err_set_wins_hold", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    check("err_drain_count", count, 0);

    // Reset in the middle of a handshake.
    send_full(8'h31);
    raise_wait(8'hC3, lat);
    check("mid_count2", count, 2);
    check("mid_ack", ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    lat = 0;
    while (!ack && lat < 60) begin
      tick();
      lat++;
    end
    check("mid_recapture_lat", lat, 3);
    check("mid_recapture_count", count, 1);
    check("mid_recapture_data", out_data, 8'hC3);
    drop_wait(lat);

    // Randomized transfers against the queue model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    prev_ack = 1'b0;
    pop_pend = 0;
    popped   = 0;
    max_cnt  = 0;
    snd_done = 0;
    mon_en   = 1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send_full(8'(16 + i));
        end
        snd_done = 1;
      end
      begin
        while (!snd_done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    out_ready = 1'b1;
    repeat (8) tick();
    mon_en = 0;
    out_ready = 1'b0;
    check("rnd_drained", q.size(), 0);
    check("rnd_popped", popped, 10);
    check("rnd_max_count_ok", (max_cnt <= 4), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
